i2s_dac_transmitter: RTL
========================

// Module: i2s_dac_transmitter
// PURPOSE
//  Stereo I2S transmitter driving an external I2S DAC/amp (PCM5102, MAX98357 class).
//  Accepts 24-bit left/right sample pairs over a valid/ready handshake into a one-pair
//  holding buffer, then serializes them MSB-first, Philips I2S framing. Controller mode.
//  Frame timing identical to the INMP441 mic receiver: ~3.13 MHz sck, ~48.8 kHz frame.
//  Mic-in -> DSP -> DAC-out loopback with no resampling.
// PARAMETERS
//  clk_mhz   50   system clock MHz; 100 enables the /2 clk_en prescaler, else clk_en = 1
// PORTS
//  clk        in   1   system clock
//  rst        in   1   reset, asynchronous, active-high
//  in_left    in   24  left sample, two's complement
//  in_right   in   24  right sample, two's complement
//  in_valid   in   1   sample pair offered
//  in_ready   out  1   holding buffer empty; transfer when in_valid & in_ready
//  sck        out  1   I2S bit clock
//  ws         out  1   word select: 0 = left slot, 1 = right slot
//  sd         out  1   serial data, changes only on sck falling edge
//  frame_tick out  1   1-clk pulse at each left-slot start (pair consumed or underrun)
//  underrun   out  1   1-clk pulse with frame_tick when no pair was pending
// BEHAVIOUR
//  Reset (async): cnt=0, clk_en=0, ws=1, sd=0, shift=0, pending=0, active L/R=0,
//    in_ready=1, frame_tick=0, underrun=0. All state advances only when clk_en=1.
//  cnt: 9-bit free-running, wraps 511->0. sck = cnt[3] (16 clk_en ticks per sck).
//  ws toggles at cnt==15 (coincident with sck falling edge); ws period = 1024 ticks.
//  Slot = 32 sck: 24 data bits MSB-first, then 8 zero bits.
//  Frame start: cnt==15 && ws==1 (ws about to go 0).
//    If pending: active_L/R <= buffer, pending <= 0, frame_tick=1.
//    Else: active_L/R <= 0, frame_tick=1, underrun=1.
//  Slot load at cnt==31: shift <= ws ? active_R : active_L. sd <= MSB.
//    MSB thus appears one sck after the ws edge (I2S delay).
//  Shift on cnt[3:0]==15 for cnt in [47..399]: shift <= {shift[22:0],1'b0}, sd <= new MSB.
//    Bit k (23..0) is valid for the sck period starting at tick 32+16*(23-k).
//  After bit 0 the shifter holds zeros: sd=0 until the next slot load.
//  sd is a register (no combinational path to pins).
//  Handshake:
//    in_ready = ~pending (registered state).
//    Accept sets pending and latches in_left/in_right.
//    Data must not change while in_valid & ~in_ready.
//  Simultaneous accept and frame start with pending=0: the pair is buffered for the
//    NEXT frame; this frame is an underrun. Pending=1 blocks accept (in_ready=0).
//  Max accept rate is one pair per frame; in_ready rises on the tick after frame start.
//  Reset mid-frame: all outputs return to reset values immediately.
//    The first frame start after release is at tick 15; underrun unless a pair arrived.
//  clk_mhz==100: clk_en toggles each clk. Timing in clk cycles doubles; rates unchanged.
//  Handshake logic runs every clk, not gated by clk_en.
// STRUCTURE
//  Package i2s_pkg holds shared definitions and the sample typedef used by both
//  inmp441_mic_i2s_receiver and this block:
//    I2S_SAMPLE_W=24, I2S_CNT_W=9
//    I2S_WS_TOGGLE=15, I2S_SLOT_LOAD=31, I2S_LAST_SHIFT=399
//    sample_t = logic signed [23:0]
//  One sub-module: i2s_frame_timer (clk_en prescaler, cnt, sck, ws).
//    Reusable by the receiver.
//  Top: holding buffer, handshake, frame-start logic, shifter.
// TESTING
//  1 Reset: assert rst asynchronously mid-frame.
//    -> ws=1, sck=0, sd=0, in_ready=1 within the same clk, no edge needed.
//  2 Serialization: send L=0xA5C3F1, R=0x000001 before tick 15.
//    Left slot MSB at tick 32. Decoding sd at sck rising edges yields exactly these values.
//    Bits 24..31 of each slot decode as 0.
//  3 Underrun: no in_valid for 2 frames.
//    -> underrun pulses at each frame_tick; sd stays 0 for whole frames.
//  4 Backpressure: hold in_valid=1 with 3 distinct pairs.
//    in_ready drops after first accept, one accept per frame.
//    Pairs transmitted in order; none lost or duplicated.
//  5 Coincident accept: in_valid first raised in the frame-start cycle.
//    -> that frame underruns; the pair is sent in the next frame.
//  6 clk_mhz=100: ws period = 2048 clk, sck period = 32 clk.
//    Scenario 2 decodes identically.
//  Loopback: this block's sd feeds the receiver's sd input.
//    The receiver's value equals the sent left sample.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the DAC transmitter and the INMP441 mic receiver.
// Holds the sample type, the frame-counter width and the counter positions
// at which word select toggles, slots load and the last data bit shifts out.
package i2s_pkg;

    localparam int unsigned I2S_SAMPLE_W = 24;
    localparam int unsigned I2S_CNT_W    = 9;

    // Counter positions within one 512-tick slot (16 ticks per sck period)
    localparam logic [I2S_CNT_W-1:0] I2S_WS_TOGGLE   = 9'd15;
    localparam logic [I2S_CNT_W-1:0] I2S_SLOT_LOAD   = 9'd31;
    localparam logic [I2S_CNT_W-1:0] I2S_FIRST_SHIFT = 9'd47;
    localparam logic [I2S_CNT_W-1:0] I2S_LAST_SHIFT  = 9'd399;

    typedef logic signed [I2S_SAMPLE_W-1:0] sample_t;

    // Pick the sample for the slot that word select is announcing (1 = right)
    function automatic logic [I2S_SAMPLE_W-1:0] slot_word(
        input logic    ws_val,
        input sample_t left_val,
        input sample_t right_val
    );
        return ws_val ? right_val : left_val;
    endfunction

endpackage

// File: rtl/i2s_dac_transmitter_if.sv
// Sample-pair handshake between a producer (DSP) and the I2S transmitter.
//   in_left/in_right : 24-bit two's complement samples
//   in_valid         : pair offered by the producer
//   in_ready         : transmitter holding buffer empty
// master = producer side, slave = transmitter side.
interface i2s_dac_transmitter_if;

    i2s_pkg::sample_t in_left;
    i2s_pkg::sample_t in_right;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_left, output in_right, output in_valid, input in_ready);
    modport slave  (input in_left, input in_right, input in_valid, output in_ready);

endinterface

// File: rtl/i2s_frame_timer.sv
// I2S controller frame timing: optional /2 tick prescaler, 9-bit free-running
// tick counter, bit clock and word select. Shared with the mic receiver.
// Ports:
//   clk, rst : system clock, async active-high reset
//   clk_en   : tick enable (toggles each clk when clk_mhz == 100, else 1)
//   cnt      : tick counter, wraps 511 -> 0
//   sck      : bit clock, cnt[3]
//   ws       : word select, toggles on the sck falling edge at cnt == 15
module i2s_frame_timer
    import i2s_pkg::*;
#(
    parameter int clk_mhz = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 clk_en,
    output logic [I2S_CNT_W-1:0] cnt,
    output logic                 sck,
    output logic                 ws
);

    logic [I2S_CNT_W-1:0] cnt_r;
    logic                 ws_r;

    generate
        if (clk_mhz == 100) begin : g_div2
            logic clk_en_r;

            // Divide-by-two tick enable so the I2S rates match the 50 MHz build
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    clk_en_r <= 1'b0;
                end else begin
                    clk_en_r <= ~clk_en_r;
                end
            end

            assign clk_en = clk_en_r;
        end else begin : g_nodiv
            assign clk_en = 1'b1;
        end
    endgenerate

    // Tick counter and word select; ws starts high so the first left slot begins at tick 15
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 9'd0;
            ws_r  <= 1'b1;
        end else if (clk_en) begin
            cnt_r <= cnt_r + 9'd1;
            if (cnt_r == I2S_WS_TOGGLE) begin
                ws_r <= ~ws_r;
            end
        end
    end

    assign cnt = cnt_r;
    assign sck = cnt_r[3];
    assign ws  = ws_r;

endmodule

// File: rtl/i2s_dac_transmitter.sv
// Stereo I2S transmitter (Philips framing, controller mode) for PCM5102 /
// MAX98357 class DACs. A one-pair holding buffer accepts samples over a
// valid/ready handshake; each frame start moves the buffer into the active
// pair (or zeros on underrun) and the shifter sends 24 bits MSB-first plus
// 8 zero bits per slot.
// Ports:
//   clk, rst   : system clock, async active-high reset
//   in_if      : sample-pair handshake (slave side)
//   sck, ws    : I2S bit clock and word select (0 = left)
//   sd         : serial data, flop output, changes on sck falling edges
//   frame_tick : 1-clk pulse at each left-slot start
//   underrun   : 1-clk pulse with frame_tick when no pair was pending
module i2s_dac_transmitter
    import i2s_pkg::*;
#(
    parameter int clk_mhz = 50
) (
    input  logic                        clk,
    input  logic                        rst,
    i2s_dac_transmitter_if.slave        in_if,
    output logic                        sck,
    output logic                        ws,
    output logic                        sd,
    output logic                        frame_tick,
    output logic                        underrun
);

    logic                    clk_en_s;
    logic [I2S_CNT_W-1:0]    cnt_s;
    logic                    ws_s;

    sample_t                 buf_left_r;
    sample_t                 buf_right_r;
    sample_t                 act_left_r;
    sample_t                 act_right_r;
    logic [I2S_SAMPLE_W-1:0] shift_r;
    logic                    pending_r;
    logic                    frame_tick_r;
    logic                    underrun_r;

    logic                    accept_s;
    logic                    frame_start_s;
    logic                    slot_load_s;
    logic                    shift_en_s;
    logic                    data_bit_s;

    i2s_frame_timer #(.clk_mhz(clk_mhz)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en_s),
        .cnt    (cnt_s),
        .sck    (sck),
        .ws     (ws_s)
    );

    // Event decode; frame start uses the pre-toggle ws, so ws==1 marks the left slot coming up
    always_comb begin
        accept_s      = in_if.in_valid & ~pending_r;
        frame_start_s = clk_en_s & (cnt_s == I2S_WS_TOGGLE) & ws_s;
        slot_load_s   = clk_en_s & (cnt_s == I2S_SLOT_LOAD);
        shift_en_s    = clk_en_s & (cnt_s[3:0] == 4'hF) & (cnt_s >= I2S_FIRST_SHIFT);
        data_bit_s    = (cnt_s <= I2S_LAST_SHIFT);
    end

    // Holding buffer; runs every clk. An accept in the frame-start cycle wins
    // over the clear, so that pair waits for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r   <= 1'b0;
            buf_left_r  <= 24'sd0;
            buf_right_r <= 24'sd0;
        end else if (accept_s) begin
            pending_r   <= 1'b1;
            buf_left_r  <= in_if.in_left;
            buf_right_r <= in_if.in_right;
        end else if (frame_start_s) begin
            pending_r   <= 1'b0;
        end
    end

    // Active pair and frame status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_left_r   <= 24'sd0;
            act_right_r  <= 24'sd0;
            frame_tick_r <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            frame_tick_r <= frame_start_s;
            underrun_r   <= frame_start_s & ~pending_r;
            if (frame_start_s) begin
                act_left_r  <= pending_r ? buf_left_r  : 24'sd0;
                act_right_r <= pending_r ? buf_right_r : 24'sd0;
            end
        end
    end

    // Output shifter; its MSB is the sd pin. Past the last data bit it is cleared
    // so the 8 pad bits of every slot are zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= 24'd0;
        end else if (slot_load_s) begin
            shift_r <= slot_word(ws_s, act_left_r, act_right_r);
        end else if (shift_en_s && data_bit_s) begin
            shift_r <= {shift_r[I2S_SAMPLE_W-2:0], 1'b0};
        end else if (shift_en_s) begin
            shift_r <= 24'd0;
        end
    end

    assign sd             = shift_r[I2S_SAMPLE_W-1];
    assign ws             = ws_s;
    assign frame_tick     = frame_tick_r;
    assign underrun       = underrun_r;
    assign in_if.in_ready = ~pending_r;

endmodule
